// File: rtl/prewitt_window_ctrl.sv
// Sequencing controller for the 3x3 Prewitt window datapath.
// Tracks column/row of the incoming pixel stream, drives line-buffer writes
// and the datapath valid, and carries result framing tags through a pipe
// that advances in lock-step with the datapath so they line up with dout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a beat with s_sof; other beats are dropped
// ST_FILL  | rows 0 and 1: priming the line buffers, no results
// ST_RUN   | rows 2..PIC_HEIGHT-1: interior results produced from col 2
// ST_FLUSH | PIPE_LAT drain beats to push the last results out; stalls input
module prewitt_window_ctrl #(
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272,
  parameter int PIPE_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic       s_sof,
  input  logic       s_eol,
  output logic       s_ready,
  output logic       lb_wr_en,
  output logic [8:0] lb_addr,
  output logic       lb_rotate,
  output logic       win_valid,
  output logic       m_valid,
  output logic       m_sof,
  output logic       m_eol,
  output logic       frame_done,
  output logic       err_len,
  output logic       err_sof
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_t;

  localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);
  localparam int         FW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(PIPE_LAT - 1);

  state_t              state, state_nxt;
  logic [8:0]          col, col_nxt;
  logic [8:0]          row, row_nxt;
  logic [FW-1:0]       flush_cnt, flush_cnt_nxt;
  logic                frame_end;

  logic                accept;
  logic                in_frame;
  logic                restart;
  logic                frame_beat;
  logic [8:0]          beat_col;
  logic [8:0]          beat_row;
  logic                line_done;
  logic                len_bad;
  logic                tag_v, tag_sof, tag_eol;

  logic [PIPE_LAT-1:0] pipe_v, pipe_s, pipe_e;

  // Beat qualification and column/row of the current beat. A sof beat is
  // always col0,row0 of a fresh frame, whatever the counters held before.
  assign s_ready    = (state != ST_FLUSH);
  assign accept     = s_valid & s_ready;
  assign in_frame   = (state == ST_FILL) || (state == ST_RUN);
  assign restart    = accept & s_sof;
  assign frame_beat = accept & (in_frame | s_sof);
  assign beat_col   = restart ? 9'd0 : col;
  assign beat_row   = restart ? 9'd0 : row;

  // eol on a sof beat is ignored for line termination but still flagged
  // as a length error since col0 is never the last column.
  assign line_done  = frame_beat & ((beat_col == COL_LAST) | (s_eol & ~s_sof));
  assign len_bad    = frame_beat & ((s_eol & (beat_col != COL_LAST)) |
                                    (~s_eol & (beat_col == COL_LAST)));

  assign lb_wr_en   = frame_beat;
  assign lb_addr    = beat_col;
  assign win_valid  = frame_beat | (state == ST_FLUSH);

  // Tag for the window centred one row/col behind this beat; only RUN-state
  // beats from column 2 onward complete a full 3x3 interior window.
  assign tag_v   = frame_beat & (state == ST_RUN) & ~s_sof & (beat_col >= 9'd2);
  assign tag_sof = tag_v & (row == 9'd2) & (col == 9'd2);
  assign tag_eol = tag_v & (col == COL_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, column/row advance and flush down-counter.
  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    flush_cnt_nxt = flush_cnt;
    frame_end     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (restart) state_nxt = ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        if (line_done && beat_row == ROW_LAST)
          state_nxt = ST_FLUSH;
        else if (line_done && beat_row == 9'd1)
          state_nxt = ST_RUN;
        else if (restart)
          state_nxt = ST_FILL;
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end else begin
          flush_cnt_nxt = flush_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (frame_beat) begin
      if (line_done) begin
        col_nxt = 9'd0;
        row_nxt = beat_row + 9'd1;
      end else begin
        col_nxt = beat_col + 9'd1;
        row_nxt = beat_row;
      end
    end

    if (state_nxt == ST_FLUSH && state != ST_FLUSH) begin
      col_nxt       = 9'd0;
      row_nxt       = 9'd0;
      flush_cnt_nxt = FLUSH_LOAD;
    end
  end

  // Position counters and flush timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= 9'd0;
      row       <= 9'd0;
      flush_cnt <= '0;
    end else begin
      col       <= col_nxt;
      row       <= row_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Tag pipe: advances only on datapath beats; a new sof drops pending tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_s <= '0;
      pipe_e <= '0;
    end else if (restart) begin
      pipe_v <= '0;
      pipe_s <= '0;
      pipe_e <= '0;
    end else if (win_valid) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_s[i] <= pipe_s[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
      pipe_v[0] <= tag_v;
      pipe_s[0] <= tag_sof;
      pipe_e[0] <= tag_eol;
    end
  end

  // Registered single-cycle output framing and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      lb_rotate  <= 1'b0;
      err_len    <= 1'b0;
      err_sof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      m_valid    <= win_valid & ~restart & pipe_v[PIPE_LAT-1];
      m_sof      <= win_valid & ~restart & pipe_v[PIPE_LAT-1] & pipe_s[PIPE_LAT-1];
      m_eol      <= win_valid & ~restart & pipe_v[PIPE_LAT-1] & pipe_e[PIPE_LAT-1];
      lb_rotate  <= line_done;
      err_len    <= len_bad;
      err_sof    <= restart & in_frame;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_prewitt_window_ctrl.sv
// Bench for prewitt_window_ctrl with an 8x5 picture and a 2-beat datapath.
// Expected result tags are queued as beats are driven and popped as m_valid
// appears; event counters collected on the falling edge back the per-test checks.
module tb_prewitt_window_ctrl;

  localparam int W = 8;
  localparam int H = 5;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_sof, s_eol;
  logic       s_ready, lb_wr_en, lb_rotate, win_valid;
  logic [8:0] lb_addr;
  logic       m_valid, m_sof, m_eol, frame_done, err_len, err_sof;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  bit         sb_en = 1'b1;
  bit         prev_wv = 1'b0;
  bit         prev_nrdy = 1'b0;

  int cnt_mv, cnt_msof, cnt_meol, cnt_rot, cnt_fd, cnt_elen, cnt_esof;
  int cnt_wr, cnt_wv, cnt_nrdy;

  prewitt_window_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol), .s_ready(s_ready),
    .lb_wr_en(lb_wr_en), .lb_addr(lb_addr), .lb_rotate(lb_rotate),
    .win_valid(win_valid), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol),
    .frame_done(frame_done), .err_len(err_len), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  // Falling-edge monitor: event counters plus scoreboard pop on each result.
  always @(negedge clk) begin
    if (m_valid) begin
      cnt_mv++;
      if (m_sof) cnt_msof++;
      if (m_eol) cnt_meol++;
      if (sb_en) begin
        checks++;
        if (!prev_wv) begin
          errors++;
          $display("FAIL m_valid_follow: m_valid with previous win_valid=%b, required 1", prev_wv);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: result {sof,eol}=%b%b with no expected entry", m_sof, m_eol);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if ({m_sof, m_eol} !== e) begin
            errors++;
            $display("FAIL sb_tag: {sof,eol}=%b%b, required %b", m_sof, m_eol, e);
          end
        end
      end
    end
    if (frame_done) begin
      cnt_fd++;
      checks++;
      if (!(s_ready === 1'b1 && prev_nrdy)) begin
        errors++;
        $display("FAIL fd_timing: s_ready=%b prev_not_ready=%b, required 1 and 1", s_ready, prev_nrdy);
      end
    end
    if (lb_rotate) cnt_rot++;
    if (err_len)   cnt_elen++;
    if (err_sof)   cnt_esof++;
    if (lb_wr_en)  cnt_wr++;
    if (win_valid) cnt_wv++;
    if (s_ready === 1'b0) cnt_nrdy++;
    prev_wv   = (win_valid === 1'b1);
    prev_nrdy = (s_ready === 1'b0);
  end

  task automatic clear_counts();
    cnt_mv = 0; cnt_msof = 0; cnt_meol = 0; cnt_rot = 0; cnt_fd = 0;
    cnt_elen = 0; cnt_esof = 0; cnt_wr = 0; cnt_wv = 0; cnt_nrdy = 0;
  endtask

  // One frame beat; queues the expected interior result when push is set.
  task automatic drive_beat(input int r, input int c, input bit sof, input bit eol,
                            input bit gap, input bit push);
    if (push && r >= 2 && c >= 2)
      exp_q.push_back({(r == 2 && c == 2), (c == W - 1)});
    s_valid = 1'b1; s_sof = sof; s_eol = eol;
    #1;
    checks++;
    if (lb_wr_en !== 1'b1 || lb_addr !== 9'(c)) begin
      errors++;
      $display("FAIL beat_addr: r%0d lb_wr_en=%b lb_addr=%0d, required 1 and %0d", r, lb_wr_en, lb_addr, c);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_rows(input int r0, input int r1, input bit gap);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < W; c++)
        drive_beat(r, c, (r == 0 && c == 0), (c == W - 1), gap, 1'b1);
  endtask

  // Bounded wait for frame_done, then a few settle cycles.
  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (cnt_fd != 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    checks++;
    if (s_ready !== 1'b1 || lb_wr_en !== 1'b0 || lb_addr !== 9'd0 || lb_rotate !== 1'b0 ||
        win_valid !== 1'b0 || m_valid !== 1'b0 || m_sof !== 1'b0 || m_eol !== 1'b0 ||
        frame_done !== 1'b0 || err_len !== 1'b0 || err_sof !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: s_ready=%b wr=%b addr=%0d rot=%b wv=%b mv=%b fd=%b el=%b es=%b, required s_ready=1 rest 0",
               s_ready, lb_wr_en, lb_addr, lb_rotate, win_valid, m_valid, frame_done, err_len, err_sof);
    end
  endtask

  task automatic test_full_frame(input bit gap);
    clear_counts();
    send_rows(0, H - 1, gap);
    wait_idle();
    checks++;
    if (cnt_mv !== 18 || cnt_msof !== 1 || cnt_meol !== 3) begin
      errors++;
      $display("FAIL frame_results gap=%0d: mv=%0d sof=%0d eol=%0d, required 18 1 3", gap, cnt_mv, cnt_msof, cnt_meol);
    end
    checks++;
    if (cnt_rot !== 5 || cnt_fd !== 1 || cnt_elen !== 0 || cnt_esof !== 0) begin
      errors++;
      $display("FAIL frame_status gap=%0d: rot=%0d fd=%0d el=%0d es=%0d, required 5 1 0 0", gap, cnt_rot, cnt_fd, cnt_elen, cnt_esof);
    end
    checks++;
    if (cnt_nrdy !== L || cnt_wv !== W * H + L || cnt_wr !== W * H) begin
      errors++;
      $display("FAIL frame_flush gap=%0d: not_ready=%0d wv=%0d wr=%0d, required %0d %0d %0d",
               gap, cnt_nrdy, cnt_wv, cnt_wr, L, W * H + L, W * H);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL frame_leftover gap=%0d: %0d pending, required 0", gap, exp_q.size());
    end
  endtask

  task automatic test_short_line();
    clear_counts();
    send_rows(0, 2, 1'b0);
    for (int c = 0; c <= 5; c++)
      drive_beat(3, c, 1'b0, (c == 5), 1'b0, 1'b1);
    send_rows(4, 4, 1'b0);
    wait_idle();
    checks++;
    if (cnt_mv !== 16 || cnt_msof !== 1 || cnt_meol !== 2) begin
      errors++;
      $display("FAIL short_results: mv=%0d sof=%0d eol=%0d, required 16 1 2", cnt_mv, cnt_msof, cnt_meol);
    end
    checks++;
    if (cnt_elen !== 1 || cnt_rot !== 5 || cnt_fd !== 1 || cnt_esof !== 0) begin
      errors++;
      $display("FAIL short_status: el=%0d rot=%0d fd=%0d es=%0d, required 1 5 1 0", cnt_elen, cnt_rot, cnt_fd, cnt_esof);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL short_leftover: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_sof_restart();
    int mv_mark;
    clear_counts();
    send_rows(0, 2, 1'b0);
    for (int c = 0; c <= 3; c++)
      drive_beat(3, c, 1'b0, 1'b0, 1'b0, 1'b0);
    mv_mark = cnt_mv;
    send_rows(0, 1, 1'b0);
    checks++;
    if (cnt_mv !== mv_mark || cnt_esof !== 1) begin
      errors++;
      $display("FAIL sof_quiet: mv grew %0d->%0d es=%0d, required no growth and 1", mv_mark, cnt_mv, cnt_esof);
    end
    send_rows(2, H - 1, 1'b0);
    wait_idle();
    checks++;
    if (cnt_mv !== 24 || cnt_msof !== 2 || cnt_meol !== 4) begin
      errors++;
      $display("FAIL sof_results: mv=%0d sof=%0d eol=%0d, required 24 2 4", cnt_mv, cnt_msof, cnt_meol);
    end
    checks++;
    if (cnt_esof !== 1 || cnt_elen !== 0 || cnt_fd !== 1 || cnt_rot !== 8) begin
      errors++;
      $display("FAIL sof_status: es=%0d el=%0d fd=%0d rot=%0d, required 1 0 1 8", cnt_esof, cnt_elen, cnt_fd, cnt_rot);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sof_leftover: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_idle_discard();
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_sof = 1'b0; s_eol = (i == 4);
      #1;
      checks++;
      if (lb_wr_en !== 1'b0 || win_valid !== 1'b0 || s_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_beat%0d: wr=%b wv=%b s_ready=%b, required 0 0 1", i, lb_wr_en, win_valid, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_eol = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (cnt_wr !== 0 || cnt_wv !== 0 || cnt_mv !== 0 || cnt_elen !== 0 || cnt_rot !== 0) begin
      errors++;
      $display("FAIL idle_counts: wr=%0d wv=%0d mv=%0d el=%0d rot=%0d, required all 0", cnt_wr, cnt_wv, cnt_mv, cnt_elen, cnt_rot);
    end
  endtask

  task automatic test_async_reset();
    sb_en = 1'b0;
    send_rows(0, 1, 1'b0);
    for (int c = 0; c <= 4; c++)
      drive_beat(2, c, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    test_reset();
    clear_counts();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (cnt_mv !== 0 || cnt_rot !== 0 || cnt_fd !== 0 || cnt_elen !== 0 || cnt_esof !== 0) begin
      errors++;
      $display("FAIL reset_quiet: mv=%0d rot=%0d fd=%0d el=%0d es=%0d, required all 0", cnt_mv, cnt_rot, cnt_fd, cnt_elen, cnt_esof);
    end
    rst_n = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    @(posedge clk); #1;
    test_full_frame(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_short_line();
    test_sof_restart();
    test_idle_discard();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
